num_display_driver: RTL and testbench
=====================================

NUM_DISPLAY_DRIVER -- requirements
Module: num_display_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of 7-segment digits driven (1..8).
REQ-002 SHALL have parameter WIDTH, default 16, input value width in bits (4..32).
REQ-003 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request conversion of value; sampled only in IDLE.
REQ-006 SHALL have port value  input  WIDTH  number to display, captured on accepted start.
REQ-007 SHALL have port signed_mode  input  1  value is two's complement; captured with value.
REQ-008 SHALL have port blank_lz  input  1  blank leading zeros; captured with value.
REQ-009 SHALL have port busy  output  1  conversion in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse, segs hold the new result.
REQ-011 SHALL have port segs  output  7*DIGITS  active-low segments; digit k at [7k+6:7k], digit 0 least significant.

Function
REQ-012 SHALL encode glyphs (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, off=1111111.
REQ-013 SHALL implement FSM IDLE -> SHIFT -> MAP -> IDLE; start=1 in IDLE moves to SHIFT, otherwise stays in IDLE.
REQ-014 SHALL, on accepting start, capture magnitude = value (unsigned), or |value| when signed_mode=1 and value[WIDTH-1]=1, plus negative flag, signed_mode and blank_lz.
REQ-015 SHALL compute magnitude |most-negative| (e.g. 32768 for WIDTH=16) correctly as a WIDTH-bit unsigned value.
REQ-016 SHALL convert by shift-add-3 (double dabble): SHIFT lasts exactly WIDTH cycles, one magnitude bit per cycle MSB first, add 3 to each BCD nibble >=5 before each shift.
REQ-017 SHALL size the internal BCD register to ceil(WIDTH/3)+1 nibbles, never truncating.
REQ-018 SHALL in MAP (one cycle) register segs and assert done in the following cycle, concurrently with the new segs; latency start-accept edge to done = WIDTH+2 cycles.
REQ-019 SHALL hold busy=1 from the cycle after start acceptance through MAP, and busy=0 when done=1.
REQ-020 SHALL ignore start while busy=1; a start asserted in the done cycle is accepted (FSM is in IDLE).
REQ-021 SHALL hold segs stable between done pulses; value/mode inputs changing mid-conversion have no effect.
REQ-022 SHALL define available digits A = DIGITS when not negative, DIGITS-1 when negative (leftmost digit reserved for sign).
REQ-023 SHALL flag overflow when any BCD nibble at index >= A is nonzero; on overflow all DIGITS show dash.
REQ-024 SHALL, when negative and not overflow, show dash on digit DIGITS-1 regardless of blank_lz.
REQ-025 SHALL, when blank_lz=1, show off on digits above the most significant nonzero digit within A; digit 0 is never blanked (value 0 shows "0").
REQ-026 SHALL, when blank_lz=0, show all A digits as decimal including leading zeros.

Reset
REQ-027 SHALL on rst_n=0 asynchronously force FSM=IDLE, busy=0, done=0, segs all off (every bit 1), BCD/shift registers 0.
REQ-028 SHALL abort any conversion on reset mid-operation; no done pulse follows reset release until a new start.
REQ-029 SHALL accept start no earlier than the first rising clk edge after rst_n deasserts.

Verification (DIGITS=4, WIDTH=16)
REQ-030 SHALL cover: value=1234, signed_mode=0, blank_lz=0 -> digits3..0 = 1111001,0100100,0110000,0011001; done exactly 18 cycles after start edge, busy high 17 cycles.
REQ-031 SHALL cover: value=42, blank_lz=1 -> digits3..0 = off,off,0011001,0100100; value=0, blank_lz=1 -> off,off,off,1000000.
REQ-032 SHALL cover: value=10000 unsigned -> all four digits 0111111; value=9999 -> 9,9,9,9 (0010000 each).
REQ-033 SHALL cover: signed_mode=1, value=16'hFF85 (-123), blank_lz=0 -> dash,1,2,3; value=-999 -> dash,9,9,9; value=-1000 and 16'h8000 -> all dashes.
REQ-034 SHALL cover: second start pulsed 5 cycles after an accepted start -> ignored, exactly one done; start held high through done -> back-to-back conversions, one done per WIDTH+2 cycles.
REQ-035 SHALL cover: rst_n low during SHIFT cycle 8 -> busy=0, done=0, segs=all 1s immediately (before next clk edge), no subsequent done.

Source files
------------

// File: rtl/num_display_driver.sv
// -----------------------------------------------------------------------------
// num_display_driver
//
// Converts a binary number into active-low 7-segment glyphs for DIGITS digits.
// A conversion is started by pulsing start while idle. The magnitude is turned
// into BCD by shift-add-3 (one bit per cycle, MSB first, WIDTH cycles). One
// further cycle maps the BCD digits to glyphs, handling the sign, overflow and
// leading-zero blanking. The result is then presented on segs together with a
// one-cycle done pulse.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   conversion request, only looked at while idle
//   value        in   [WIDTH-1:0] number to display, captured with start
//   signed_mode  in   treat value as two's complement, captured with start
//   blank_lz     in   blank leading zeros, captured with start
//   busy         out  conversion in progress
//   done         out  one-cycle pulse, segs carry the new result
//   segs         out  [7*DIGITS-1:0] active-low gfedcba; digit k at [7k+6:7k]
// -----------------------------------------------------------------------------
module num_display_driver #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  signed_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   segs
);

  // BCD nibbles needed for WIDTH bits, plus one spare so the add-3 step can
  // never carry out of the register.
  localparam int NB   = (WIDTH + 2) / 3 + 1;
  // Padded digit view so every display digit has a nibble to look at.
  localparam int PADN = (NB > DIGITS) ? NB : DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_MAP   = 2'd2;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Decimal digit to active-low glyph; anything outside 0..9 shows off.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

  // Add 3 to every nibble that is 5 or more, ahead of the next shift.
  function automatic logic [4*NB-1:0] dd_adjust(input logic [4*NB-1:0] b);
    logic [4*NB-1:0] r;
    r = b;
    for (int i = 0; i < NB; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [4*NB-1:0]      bcd_q, bcd_d;
  logic                 neg_q, neg_d;
  logic                 blank_q, blank_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [7*DIGITS-1:0]  segs_q, segs_d;

  logic [4*NB-1:0]      adj_s;
  logic [4*PADN-1:0]    bcd_pad_s;
  logic [7*DIGITS-1:0]  map_s;
  logic                 ovf_s;
  logic                 lead_s;
  logic [3:0]           nib_s;
  int                   avail_s;

  // Glyph mapping of the finished BCD value: overflow, sign and blanking.
  always_comb begin
    bcd_pad_s             = '0;
    bcd_pad_s[4*NB-1:0]   = bcd_q;
    avail_s               = neg_q ? (DIGITS - 1) : DIGITS;
    ovf_s                 = 1'b0;
    map_s                 = '1;
    nib_s                 = 4'd0;
    for (int i = 0; i < NB; i++) begin
      if ((i >= avail_s) && (bcd_q[4*i +: 4] != 4'd0)) begin
        ovf_s = 1'b1;
      end else begin
        ovf_s = ovf_s;
      end
    end
    // Walk from the leftmost digit down; lead_s stays set while only zeros
    // have been seen, which is what gets blanked.
    lead_s = blank_q;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib_s = bcd_pad_s[4*k +: 4];
      if (ovf_s) begin
        map_s[7*k +: 7] = SEG_DASH;
      end else if (k >= avail_s) begin
        // Only reachable for the sign position of a negative number.
        map_s[7*k +: 7] = SEG_DASH;
      end else if (lead_s && (nib_s == 4'd0) && (k != 0)) begin
        map_s[7*k +: 7] = SEG_OFF;
      end else begin
        map_s[7*k +: 7] = glyph(nib_s);
        lead_s          = 1'b0;
      end
    end
  end

  // Conversion sequencer: capture, shift-add-3, then map.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    blank_d = blank_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    segs_d  = segs_q;
    adj_s   = dd_adjust(bcd_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bcd_d   = '0;
          blank_d = blank_lz;
          neg_d   = signed_mode & value[WIDTH-1];
          // Two's complement negate; the most negative value maps onto
          // itself, which read as unsigned is exactly its magnitude.
          if (signed_mode && value[WIDTH-1]) begin
            mag_d = ~value + WIDTH'(1);
          end else begin
            mag_d = value;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        bcd_d = {adj_s[4*NB-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_MAP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_MAP: begin
        segs_d  = map_s;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset blanks the display and aborts any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      segs_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      segs_q  <= segs_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign segs = segs_q;

endmodule

// File: tb/tb_num_display_driver.sv
module tb_num_display_driver;

  localparam int DIGITS = 4;
  localparam int WIDTH  = 16;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;
  localparam logic [6:0] GLY [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                      7'b0110000, 7'b0011001, 7'b0010010,
                                      7'b0000010, 7'b1111000, 7'b0000000,
                                      7'b0010000};

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [WIDTH-1:0]    value;
  logic                signed_mode;
  logic                blank_lz;
  logic                busy;
  logic                done;
  logic [7*DIGITS-1:0] segs;

  int pass_cnt  = 0;
  int total_cnt = 0;

  num_display_driver #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .signed_mode(signed_mode), .blank_lz(blank_lz),
    .busy(busy), .done(done), .segs(segs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display from decimal arithmetic on the number itself.
  function automatic logic [27:0] model(input logic [15:0] v, input logic sm, input logic bl);
    logic [27:0] r;
    int mag, avail, lim, msd, tmp;
    int d[4];
    bit neg;
    neg   = sm && v[15];
    mag   = neg ? (65536 - int'(v)) : int'(v);
    avail = neg ? 3 : 4;
    lim   = neg ? 1000 : 10000;
    if (mag >= lim) return {DASH, DASH, DASH, DASH};
    tmp = mag;
    for (int k = 0; k < 4; k++) begin
      d[k] = tmp % 10;
      tmp  = tmp / 10;
    end
    msd = 0;
    for (int k = 0; k < avail; k++) if (d[k] != 0) msd = k;
    for (int k = 0; k < 4; k++) begin
      if (k >= avail)            r[7*k +: 7] = DASH;
      else if (bl && k > msd)    r[7*k +: 7] = OFF;
      else                       r[7*k +: 7] = GLY[d[k]];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one conversion, scrambles the inputs while it runs, and returns
  // the result, the edge count to done (accept edge = 1) and busy cycles.
  task automatic run_conv(input logic [15:0] v, input logic sm, input logic bl,
                          output logic [27:0] s, output int lat, output int bcnt,
                          output bit to);
    start = 1'b1; value = v; signed_mode = sm; blank_lz = bl;
    tick();
    lat = 1; bcnt = 0; start = 1'b0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      value = 16'($urandom); signed_mode = 1'($urandom); blank_lz = 1'($urandom);
      tick();
      lat++;
    end
    to = !done;
    s  = segs;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; value = 16'd0; signed_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (segs !== 28'hFFFFFFF) $display("FAIL reset_segs got %h want fffffff", segs); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] tv [10] = '{16'd1234, 16'd42, 16'd0, 16'd10000, 16'd9999,
                             16'hFF85, 16'hFC19, 16'hFC18, 16'h8000, 16'hFFFB};
    logic        ts [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        tb [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [27:0] s, held, exp;
    int lat, bcnt;
    bit to;
    for (int i = 0; i < 10; i++) begin
      run_conv(tv[i], ts[i], tb[i], s, lat, bcnt, to);
      exp = model(tv[i], ts[i], tb[i]);
      total_cnt++; if (to) $display("FAIL dir_timeout case %0d got no done want done", i); else pass_cnt++;
      total_cnt++; if (s !== exp) $display("FAIL dir_segs case %0d got %h want %h", i, s, exp); else pass_cnt++;
      total_cnt++; if (lat !== 18) $display("FAIL dir_latency case %0d got %0d want 18", i, lat); else pass_cnt++;
      total_cnt++; if (bcnt !== 17) $display("FAIL dir_busy_cycles case %0d got %0d want 17", i, bcnt); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL dir_busy_at_done case %0d got %b want 0", i, busy); else pass_cnt++;
      held = segs;
      repeat (3) tick();
      total_cnt++; if (done !== 1'b0) $display("FAIL dir_done_pulse case %0d got %b want 0", i, done); else pass_cnt++;
      total_cnt++; if (segs !== held) $display("FAIL dir_segs_hold case %0d got %h want %h", i, segs, held); else pass_cnt++;
    end
    // Fixed glyph strings for the 1234 and -123 cases.
    run_conv(16'd1234, 1'b0, 1'b0, s, lat, bcnt, to);
    total_cnt++; if (s !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001})
      $display("FAIL dir_1234_literal got %h want %h", s, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}); else pass_cnt++;
    run_conv(16'hFF85, 1'b1, 1'b0, s, lat, bcnt, to);
    total_cnt++; if (s !== {DASH, 7'b1111001, 7'b0100100, 7'b0110000})
      $display("FAIL dir_neg123_literal got %h want %h", s, {DASH, 7'b1111001, 7'b0100100, 7'b0110000}); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic sm, bl;
    logic [27:0] s, exp;
    int lat, bcnt, sel;
    bit to;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      v = 16'($urandom_range(0, 65535));
      else if (sel == 1) v = 16'($urandom_range(0, 1200));
      else               v = 16'(65536 - int'($urandom_range(1, 1100)));
      sm = 1'($urandom); bl = 1'($urandom);
      run_conv(v, sm, bl, s, lat, bcnt, to);
      exp = model(v, sm, bl);
      total_cnt++; if (s !== exp || to)
        $display("FAIL rand_segs v=%h sm=%b bl=%b got %h want %h", v, sm, bl, s, exp); else pass_cnt++;
      total_cnt++; if (lat !== 18) $display("FAIL rand_latency v=%h got %0d want 18", v, lat); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [27:0] first, exp;
    start = 1'b1; value = 16'd777; signed_mode = 1'b0; blank_lz = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; value = 16'd5555; blank_lz = 1'b0;
    tick();
    start = 1'b0;
    dones = 0; first = '0;
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        if (dones == 0) first = segs;
        dones++;
      end
      tick();
    end
    exp = model(16'd777, 1'b0, 1'b1);
    total_cnt++; if (dones !== 1) $display("FAIL ignore_done_count got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if (first !== exp) $display("FAIL ignore_segs got %h want %h", first, exp); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4] = '{16'd31, 16'd8086, 16'd500, 16'd1};
    logic [27:0] exp;
    int idx, edge_n, prev;
    idx = 0; prev = 0;
    start = 1'b1; value = vals[0]; signed_mode = 1'b0; blank_lz = 1'b1;
    tick();
    edge_n = 1;
    while (idx < 3 && edge_n < 200) begin
      if (done) begin
        exp = model(vals[idx], 1'b0, 1'b1);
        total_cnt++; if (segs !== exp) $display("FAIL b2b_segs conv %0d got %h want %h", idx, segs, exp); else pass_cnt++;
        if (idx > 0) begin
          total_cnt++; if (edge_n - prev !== 18) $display("FAIL b2b_period conv %0d got %0d want 18", idx, edge_n - prev); else pass_cnt++;
        end
        prev = edge_n;
        idx++;
        value = vals[idx];
      end
      tick();
      edge_n++;
    end
    total_cnt++; if (idx !== 3) $display("FAIL b2b_done_count got %0d want 3", idx); else pass_cnt++;
    start = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_reset_mid();
    int dones, lat, bcnt;
    logic [27:0] s, exp;
    bit to;
    start = 1'b1; value = 16'd4321; signed_mode = 1'b0; blank_lz = 1'b0;
    tick();
    start = 1'b0;
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (segs !== 28'hFFFFFFF) $display("FAIL rstmid_segs got %h want fffffff", segs); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) dones++;
    end
    total_cnt++; if (dones !== 0) $display("FAIL rstmid_no_done got %0d want 0", dones); else pass_cnt++;
    run_conv(16'd4321, 1'b0, 1'b0, s, lat, bcnt, to);
    exp = model(16'd4321, 1'b0, 1'b0);
    total_cnt++; if (s !== exp || to) $display("FAIL rstmid_recover got %h want %h", s, exp); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
